// File: rtl/rsv_issue_sched_if.sv
// Handshake/bus bundle for the integer reservation station scheduler.
// The slave modport is the scheduler's view. The master modport is the
// view of the decode/execute/ROB environment that drives it.
interface rsv_issue_sched_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int PAY_W  = 64
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_rob_tag;
  logic              in_is_div;
  logic [TAG_W-1:0]  in_src1_tag;
  logic [TAG_W-1:0]  in_src2_tag;
  logic              in_src1_rdy;
  logic              in_src2_rdy;
  logic [PAY_W-1:0]  in_payload;
  logic              wake_valid;
  logic [TAG_W-1:0]  wake_tag;
  logic              alu_ready;
  logic              div_busy;
  logic              alu_issue;
  logic              div_issue;
  logic [TAG_W-1:0]  issue_tag;
  logic [PAY_W-1:0]  issue_payload;
  logic              alu_res_valid;
  logic [TAG_W-1:0]  alu_res_tag;
  logic [DATA_W-1:0] alu_res_data;
  logic              div_res_valid;
  logic [TAG_W-1:0]  div_res_tag;
  logic [DATA_W-1:0] div_res_data;
  logic              div_res_ready;
  logic              fill_valid;
  logic              fill_ready;
  logic [TAG_W-1:0]  fill_tag;
  logic [DATA_W-1:0] fill_data;
  logic [3:0]        occupancy;

  modport master (
    output flush, in_valid, in_rob_tag, in_is_div, in_src1_tag, in_src2_tag,
           in_src1_rdy, in_src2_rdy, in_payload, wake_valid, wake_tag,
           alu_ready, div_busy, alu_res_valid, alu_res_tag, alu_res_data,
           div_res_valid, div_res_tag, div_res_data, fill_ready,
    input  in_ready, alu_issue, div_issue, issue_tag, issue_payload,
           div_res_ready, fill_valid, fill_tag, fill_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_rob_tag, in_is_div, in_src1_tag, in_src2_tag,
           in_src1_rdy, in_src2_rdy, in_payload, wake_valid, wake_tag,
           alu_ready, div_busy, alu_res_valid, alu_res_tag, alu_res_data,
           div_res_valid, div_res_tag, div_res_data, fill_ready,
    output in_ready, alu_issue, div_issue, issue_tag, issue_payload,
           div_res_ready, fill_valid, fill_tag, fill_data, occupancy
  );
endinterface

// File: rtl/rsv_issue_sched.sv
// Integer reservation station: collapsing age queue with registered operand
// wakeup, oldest-ready issue to the ALU or the shared divider, and ROB fill
// arbitration (divider > ALU skid head > direct ALU result).
// Optional macro RSV_SCHED_PERF_EN adds saturating performance counters.
module rsv_issue_sched #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int PAY_W   = 64
) (
  input  logic        clk,
  input  logic        rst,
`ifdef RSV_SCHED_PERF_EN
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_div_stall_cnt,
  output logic [31:0] perf_wb_conflict_cnt,
`endif
  rsv_issue_sched_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_div;
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;
    logic             s1_rdy;
    logic             s2_rdy;
    logic [PAY_W-1:0] pay;
  } ent_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } res_t;

  ent_t             ent_q [ENTRIES];
  ent_t             ent_d [ENTRIES];
  logic [3:0]       occ_q, occ_d;
  logic             div_prev_q;
  res_t             skid_q [2];
  res_t             skid_d [2];
  logic [1:0]       skid_cnt_q, skid_cnt_d;

  logic [ENTRIES-1:0] elig;
  logic               issue;
  logic [IDX_W-1:0]   sel;
  ent_t               sel_ent;
  ent_t               new_ent;
  logic               alloc;
  logic [3:0]         wr_idx;
  logic [IDX_W-1:0]   src;
  logic               skid_push, skid_pop;

  // Eligibility per entry and oldest-first selection; flush and reset mute issue.
  always_comb begin
    elig = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (4'(i) < occ_q && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        if (ent_q[i].is_div) elig[i] = !bus.div_busy && !div_prev_q;
        else                 elig[i] = bus.alu_ready && (skid_cnt_q == 2'd0);
      end
    end
    issue = 1'b0;
    sel   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (elig[i]) begin
        issue = 1'b1;
        sel   = IDX_W'(i);
      end
    end
    if (rst || bus.flush) issue = 1'b0;
    sel_ent = ent_q[sel];
  end

  assign bus.alu_issue     = issue && !sel_ent.is_div;
  assign bus.div_issue     = issue && sel_ent.is_div;
  assign bus.issue_tag     = issue ? sel_ent.tag : '0;
  assign bus.issue_payload = issue ? sel_ent.pay : '0;
  assign bus.in_ready      = occ_q < 4'(ENTRIES);
  assign bus.occupancy     = occ_q;

  // Next queue contents: collapse over the issued slot, apply wakeup, append new entry.
  always_comb begin
    alloc          = bus.in_valid && bus.in_ready;
    new_ent.tag    = bus.in_rob_tag;
    new_ent.is_div = bus.in_is_div;
    new_ent.s1_tag = bus.in_src1_tag;
    new_ent.s2_tag = bus.in_src2_tag;
    new_ent.s1_rdy = bus.in_src1_rdy || (bus.wake_valid && bus.in_src1_tag == bus.wake_tag);
    new_ent.s2_rdy = bus.in_src2_rdy || (bus.wake_valid && bus.in_src2_tag == bus.wake_tag);
    new_ent.pay    = bus.in_payload;
    wr_idx         = occ_q - {3'b000, issue};
    occ_d          = occ_q - {3'b000, issue} + {3'b000, alloc};
    src            = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      src = IDX_W'(i);
      if (issue && IDX_W'(i) >= sel && i < ENTRIES - 1) src = IDX_W'(i + 1);
      ent_d[i] = ent_q[src];
      if (bus.wake_valid && ent_d[i].s1_tag == bus.wake_tag) ent_d[i].s1_rdy = 1'b1;
      if (bus.wake_valid && ent_d[i].s2_tag == bus.wake_tag) ent_d[i].s2_rdy = 1'b1;
      if (alloc && wr_idx == 4'(i)) ent_d[i] = new_ent;
    end
    if (bus.flush) occ_d = 4'd0;
  end

  // Fill source selection and skid push/pop; an ALU result that cannot go
  // straight to the ROB this cycle is parked in the skid.
  always_comb begin
    bus.fill_valid = 1'b0;
    bus.fill_tag   = '0;
    bus.fill_data  = '0;
    if (bus.div_res_valid) begin
      bus.fill_valid = 1'b1;
      bus.fill_tag   = bus.div_res_tag;
      bus.fill_data  = bus.div_res_data;
    end else if (skid_cnt_q != 2'd0) begin
      bus.fill_valid = 1'b1;
      bus.fill_tag   = skid_q[0].tag;
      bus.fill_data  = skid_q[0].data;
    end else if (bus.alu_res_valid) begin
      bus.fill_valid = 1'b1;
      bus.fill_tag   = bus.alu_res_tag;
      bus.fill_data  = bus.alu_res_data;
    end
    if (rst) begin
      bus.fill_valid = 1'b0;
      bus.fill_tag   = '0;
      bus.fill_data  = '0;
    end
    bus.div_res_ready = bus.fill_ready && !rst;

    skid_pop   = !bus.div_res_valid && (skid_cnt_q != 2'd0) && bus.fill_ready;
    skid_push  = bus.alu_res_valid &&
                 ((skid_cnt_q != 2'd0) || bus.div_res_valid || !bus.fill_ready);
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt_q;
    if (skid_pop) begin
      skid_d[0]  = skid_q[1];
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
    if (skid_push) begin
      skid_d[skid_cnt_d[0]] = '{tag: bus.alu_res_tag, data: bus.alu_res_data};
      skid_cnt_d            = skid_cnt_d + 2'd1;
    end
    if (bus.flush) skid_cnt_d = 2'd0;
  end

  // State registers; the skid is sized so that ALU issue blocking keeps it at most 2 deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      occ_q      <= 4'd0;
      div_prev_q <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_cnt_q <= 2'd0;
    end else begin
      assert (!(skid_push && !skid_pop && skid_cnt_q == 2'd2));
      ent_q      <= ent_d;
      occ_q      <= occ_d;
      div_prev_q <= bus.div_issue;
      skid_q     <= skid_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

`ifdef RSV_SCHED_PERF_EN
  logic div_stall;

  // A ready divide op held back only by the busy divider counts as a stall.
  always_comb begin
    div_stall = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (4'(i) < occ_q && ent_q[i].is_div && ent_q[i].s1_rdy && ent_q[i].s2_rdy)
        div_stall = div_stall | bus.div_busy;
    end
  end

  // Saturating event counters, cleared by reset and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt       <= '0;
      perf_div_stall_cnt   <= '0;
      perf_wb_conflict_cnt <= '0;
    end else if (bus.flush) begin
      perf_issue_cnt       <= '0;
      perf_div_stall_cnt   <= '0;
      perf_wb_conflict_cnt <= '0;
    end else begin
      if (issue && perf_issue_cnt != '1)           perf_issue_cnt       <= perf_issue_cnt + 32'd1;
      if (div_stall && perf_div_stall_cnt != '1)   perf_div_stall_cnt   <= perf_div_stall_cnt + 32'd1;
      if (skid_push && perf_wb_conflict_cnt != '1) perf_wb_conflict_cnt <= perf_wb_conflict_cnt + 32'd1;
    end
  end
`endif
endmodule
